// File: rtl/rbr_pkg.sv
// Redundant binary representation (radix-2 signed digit) shared types.
// Also holds the state type and helpers for the on-the-fly stream converter.
package rbr_pkg;

    // One radix-2 signed digit: value = plus - minus.
    typedef struct packed {
        logic plus;
        logic minus;
    } signed_digit;

    typedef enum logic {ACCUM, HOLD} otfc_state_e;

    // Numeric value of a signed digit: -1, 0 or +1 ({1,1} collapses to 0).
    function automatic logic signed [1:0] otfc_digit_val(input signed_digit dg);
        return $signed({1'b0, dg.plus}) - $signed({1'b0, dg.minus});
    endfunction

    // Digit counter width; a 1-digit word still needs a 1-bit counter.
    function automatic int otfc_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/otfc_stream_conv_if.sv
// Digit-in / word-out handshake bundle for otfc_stream_conv.
// Optional res_qm signal exists only when OTFC_QM_OUT_EN is defined.
interface otfc_stream_conv_if
    import rbr_pkg::*;
#(
    parameter int WIDTH = 16
) ();
    logic              d_valid;
    logic              d_ready;
    signed_digit       d;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH:0]    res;
`ifdef OTFC_QM_OUT_EN
    logic [WIDTH:0]    res_qm;
`endif

    // Converter side.
    modport slave (
        input  d_valid, d, res_ready,
        output d_ready, res_valid, res
`ifdef OTFC_QM_OUT_EN
        , output res_qm
`endif
    );

    // Producer/consumer side.
    modport master (
        output d_valid, d, res_ready,
        input  d_ready, res_valid, res
`ifdef OTFC_QM_OUT_EN
        , input res_qm
`endif
    );
endinterface

// File: rtl/otfc_append_step.sv
// One on-the-fly conversion step: appends a signed digit at bit position p
// to the Q / QM register pair using only OR and select (no carry chain).
module otfc_append_step
    import rbr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = otfc_cnt_w(WIDTH)
) (
    input  logic [WIDTH:0]   q,
    input  logic [WIDTH:0]   qm,
    input  signed_digit      d,
    input  logic [CNT_W-1:0] p,
    output logic [WIDTH:0]   q_next,
    output logic [WIDTH:0]   qm_next
);
    logic [WIDTH:0]    pos_bit;
    logic signed [1:0] dv;

    // Select the new Q/QM from the old pair and the digit value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pos_bit = (WIDTH+1)'(1) << p;
        dv      = otfc_digit_val(d);
        q_next  = q;
        qm_next = qm;
        if (dv == 2'sd1) begin
            q_next  = q | pos_bit;
            qm_next = q;
        end else if (dv == -2'sd1) begin
            q_next  = qm | pos_bit;
            qm_next = qm;
        end else begin
            qm_next = qm | pos_bit;
        end
    end
endmodule

// File: rtl/otfc_stream_conv.sv
// Streaming on-the-fly converter: MSD-first radix-2 signed digits in,
// (WIDTH+1)-bit two's-complement words out under valid/ready backpressure.
// Define OTFC_QM_OUT_EN to also register and export the final QM (res - 1).
module otfc_stream_conv
    import rbr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    otfc_stream_conv_if.slave   bus
);
    localparam int               CNT_W    = otfc_cnt_w(WIDTH);
    localparam logic [WIDTH:0]   QM_RST   = (WIDTH+1)'(1) << WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    otfc_state_e      state_q, state_d;
    logic [WIDTH:0]   q_q, q_d;
    logic [WIDTH:0]   qm_q, qm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   res_q, res_d;
`ifdef OTFC_QM_OUT_EN
    logic [WIDTH:0]   res_qm_q, res_qm_d;
`endif

    logic             accept;
    logic [CNT_W-1:0] pos;
    logic [WIDTH:0]   q_next, qm_next;

    // In HOLD the next word's first digit is only taken when the result leaves.
    assign bus.d_ready   = (state_q == ACCUM) || bus.res_ready;
    assign bus.res_valid = (state_q == HOLD);
    assign bus.res       = res_q;
`ifdef OTFC_QM_OUT_EN
    assign bus.res_qm    = res_qm_q;
`endif
    assign accept        = bus.d_valid && bus.d_ready;
    assign pos           = CNT_LAST - cnt_q;

    otfc_append_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .q       (q_q),
        .qm      (qm_q),
        .d       (bus.d),
        .p       (pos),
        .q_next  (q_next),
        .qm_next (qm_next)
    );

    // Next-state: clr abort, result release, digit append and word completion.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        qm_d     = qm_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
`ifdef OTFC_QM_OUT_EN
        res_qm_d = res_qm_q;
`endif
        if (clr) begin
            state_d = ACCUM;
            q_d     = '0;
            qm_d    = QM_RST;
            cnt_d   = '0;
        end else begin
            if (state_q == HOLD && bus.res_ready) begin
                state_d = ACCUM;
            end
            if (accept) begin
                if (cnt_q == CNT_LAST) begin
                    res_d    = q_next;
`ifdef OTFC_QM_OUT_EN
                    res_qm_d = qm_next;
`endif
                    state_d  = HOLD;
                    q_d      = '0;
                    qm_d     = QM_RST;
                    cnt_d    = '0;
                end else begin
                    q_d   = q_next;
                    qm_d  = qm_next;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q  <= ACCUM;
            q_q      <= '0;
            qm_q     <= QM_RST;
            cnt_q    <= '0;
            res_q    <= '0;
`ifdef OTFC_QM_OUT_EN
            res_qm_q <= QM_RST;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            qm_q     <= qm_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
`ifdef OTFC_QM_OUT_EN
            res_qm_q <= res_qm_d;
`endif
        end
    end
endmodule

// File: tb/tb_otfc_stream_conv.sv
// Directed self-checking bench for otfc_stream_conv at WIDTH=4.
// Inputs change and outputs are sampled just after the falling edge.
module tb_otfc_stream_conv;
    import rbr_pkg::*;

    localparam int W = 4;

    localparam signed_digit P = 2'b10;  // +1
    localparam signed_digit M = 2'b01;  // -1
    localparam signed_digit Z = 2'b00;  //  0
    localparam signed_digit X = 2'b11;  //  0 (redundant encoding)

    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   errors;

    otfc_stream_conv_if #(.WIDTH(W)) bus ();

    otfc_stream_conv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one digit (or idle) for the next rising edge, then settle.
    task automatic drive(input signed_digit dg, input logic v);
        @(negedge clk);
        bus.d_valid = v;
        bus.d       = dg;
        #1;
    endtask

    // Feed a 4-digit word (first digit in digs[7:6]) with res_ready=1, then
    // check the single-cycle result pulse and its value.
    task automatic run_word(input string tag, input logic [7:0] digs,
                            input logic [W:0] exp_res, input logic [W:0] exp_qm);
        bus.res_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            drive(signed_digit'(digs[7-2*i -: 2]), 1'b1);
            check({tag, " busy_valid"}, 32'(bus.res_valid), 32'd0);
        end
        drive(Z, 1'b0);
        check({tag, " valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, " res"}, 32'(bus.res), 32'(exp_res));
`ifdef OTFC_QM_OUT_EN
        check({tag, " res_qm"}, 32'(bus.res_qm), 32'(exp_qm));
`else
        if (exp_qm !== exp_qm) $display("unreachable");
`endif
        drive(Z, 1'b0);
        check({tag, " valid_drop"}, 32'(bus.res_valid), 32'd0);
    endtask

    logic [W:0] exp_words [3];
    signed_digit stream [12];

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.d_valid   = 1'b0;
        bus.d         = Z;
        bus.res_ready = 1'b1;
        #1;
        check("rst res_valid", 32'(bus.res_valid), 32'd0);
        check("rst res", 32'(bus.res), 32'd0);
        check("rst d_ready", 32'(bus.d_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: +1,0,-1,+1 -> +7, QM 6
        run_word("t1", {P, Z, M, P}, 5'b00111, 5'b00110);

        // 2: all -1 -> -15; all 0 -> 0 with QM -1; redundant zeros -> 0
        run_word("t2a", {M, M, M, M}, 5'b10001, 5'b10000);
        run_word("t2b", {Z, Z, Z, Z}, 5'b00000, 5'b11111);
        run_word("t2c", {X, X, X, X}, 5'b00000, 5'b11111);

        // 3: backpressure with digits waiting, then no-bubble restart
        bus.res_ready = 1'b0;
        drive(P, 1'b1);
        drive(Z, 1'b1);
        drive(M, 1'b1);
        drive(P, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(P, 1'b1);
            check("t3 stall d_ready", 32'(bus.d_ready), 32'd0);
            check("t3 stall valid", 32'(bus.res_valid), 32'd1);
            check("t3 stall res", 32'(bus.res), 32'h07);
        end
        drive(P, 1'b1);
        bus.res_ready = 1'b1;
        #1;
        check("t3 release d_ready", 32'(bus.d_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(P, 1'b1);
            check("t3 w2 busy_valid", 32'(bus.res_valid), 32'd0);
        end
        drive(Z, 1'b0);
        check("t3 w2 valid", 32'(bus.res_valid), 32'd1);
        check("t3 w2 res", 32'(bus.res), 32'h0f);
        drive(Z, 1'b0);
        check("t3 w2 valid_drop", 32'(bus.res_valid), 32'd0);

        // 4: three back-to-back words at one digit per cycle
        stream = '{P, Z, M, P, M, M, M, M, P, P, P, P};
        exp_words[0] = 5'b00111;
        exp_words[1] = 5'b10001;
        exp_words[2] = 5'b01111;
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) drive(stream[i], 1'b1);
            else        drive(Z, 1'b0);
            if (i < 12) check("t4 d_ready", 32'(bus.d_ready), 32'd1);
            if (i > 0) begin
                check("t4 valid", 32'(bus.res_valid), 32'((i % 4) == 0));
                if ((i % 4) == 0)
                    check("t4 res", 32'(bus.res), 32'(exp_words[i/4 - 1]));
            end
        end
        drive(Z, 1'b0);
        check("t4 valid_drop", 32'(bus.res_valid), 32'd0);

        // 5: clr discards a partial word and the digit in the clr cycle
        drive(P, 1'b1);
        drive(P, 1'b1);
        drive(P, 1'b1);
        clr = 1'b1;
        drive(Z, 1'b0);
        clr = 1'b0;
        check("t5 after clr valid", 32'(bus.res_valid), 32'd0);
        run_word("t5", {M, Z, Z, Z}, 5'b11000, 5'b10111);

        // 6a: reset mid-word
        drive(P, 1'b1);
        drive(M, 1'b1);
        drive(Z, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6a valid", 32'(bus.res_valid), 32'd0);
        check("t6a res", 32'(bus.res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6a d_ready", 32'(bus.d_ready), 32'd1);
        run_word("t6a", {Z, P, Z, M}, 5'b00011, 5'b00010);

        // 6b: reset while holding a result
        bus.res_ready = 1'b0;
        drive(P, 1'b1);
        drive(P, 1'b1);
        drive(M, 1'b1);
        drive(Z, 1'b1);
        drive(Z, 1'b0);
        check("t6b held valid", 32'(bus.res_valid), 32'd1);
        check("t6b held res", 32'(bus.res), 32'h0a);
        rst_n = 1'b0;
        #1;
        check("t6b valid", 32'(bus.res_valid), 32'd0);
        check("t6b res", 32'(bus.res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6b d_ready", 32'(bus.d_ready), 32'd1);
        run_word("t6b", {M, P, M, P}, 5'b11011, 5'b11010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/otfc_stream_conv.md
Name: otfc_stream_conv

Overview:
- Sequential on-the-fly converter. Consumes a most-significant-digit-first stream of radix-2 signed digits from an online arithmetic operator.
- Accumulates WIDTH digits per word. Emits the word as a (WIDTH+1)-bit two's-complement integer.
- Holds the result under valid/ready backpressure. Sits downstream of online multipliers/adders, upstream of conventional binary consumers.

Parameters:
- WIDTH, 16, digits per word; result width is WIDTH+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: discards the partial word and any held result.
- d_valid  in  1  digit valid.
- d_ready  out  1  digit accepted when d_valid && d_ready.
- d  in  signed_digit  digit; value = plus - minus ({1,0}=+1, {0,1}=-1, {0,0} and {1,1}=0).
- res_valid  out  1  result word valid.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res  out  WIDTH+1  Q, two's-complement value of the word: sum of d_j * 2^(WIDTH-1-j), where j=0 is the first digit.

Behaviour:
- Registers and reset values:
  - Q = 0 (WIDTH+1 bits).
  - QM = 1<<WIDTH, i.e. -2^WIDTH.
  - cnt = 0, width $clog2(WIDTH).
  - state = ACCUM.
  - Invariant QM == Q - 2^(WIDTH-j) before digit j.
- Outputs at reset: res_valid=0, res=0. rst_n asserted mid-word drops the partial word; there is no output pulse.
- Append step for accepted digit j, with p = WIDTH-1-j:
  - d=+1: Q' = Q | 1<<p; QM' = Q.
  - d=0: Q' = Q; QM' = QM | 1<<p.
  - d=-1: Q' = QM | 1<<p; QM' = QM.
  - Pure OR/select logic; no carry chain.
- States:
  - ACCUM:
    - d_ready=1, res_valid=0.
    - On accept: apply the step, cnt++.
    - On the accept with cnt==WIDTH-1: register res = Q', go to HOLD, reload Q/QM to reset values, set cnt=0.
  - HOLD:
    - res_valid=1; res is stable until the handshake.
    - d_ready = res_ready.
    - res_ready && !d_valid: go to ACCUM.
    - res_ready && d_valid: the digit is accepted as j=0 of the next word in the same cycle, so there are no bubbles.
    - If WIDTH==1, that digit completes the next word; stay in HOLD with the new res.
    - !res_ready: d_ready=0, hold everything.
- Latency: res_valid rises in the cycle after the last digit is accepted. Sustained throughput is 1 digit/cycle.
- clr has priority over all handshakes. Next cycle: Q/QM/cnt at reset values, state=ACCUM, res_valid=0. A digit presented in the same cycle as clr is dropped; d_ready is still driven per state.
- d is ignored when d_valid=0. res is unchanged except on word completion.

Optional Feature:
- Macro: OTFC_QM_OUT_EN.
- Defined:
  - Extra port res_qm out WIDTH+1, registered alongside res with value Q-1. This is the final QM, always res-1 modulo 2^(WIDTH+1).
  - Reset value 1<<WIDTH.
  - Used by downstream rounding/selection.
- Undefined: no port. The final QM is not registered; the per-digit QM register is still required.

Decomposition:
- rbr_pkg (existing) already provides signed_digit. Add to it:
  - typedef enum logic {ACCUM, HOLD} otfc_state_e;
  - helper function otfc_digit_val returning -1/0/+1.
- Sub-module otfc_append_step: combinational, parameter WIDTH.
  - Inputs: Q, QM, d, position index p.
  - Outputs: Q', QM'.
  - Instantiated once in otfc_stream_conv.

Test Plan:
1. WIDTH=4, res_ready=1, digits +1,0,-1,+1 -> res=5'b00111 (+7); res_qm=5'b00110 when OTFC_QM_OUT_EN; res_valid high exactly 1 cycle, the cycle after the 4th accept.
2. WIDTH=4, digits -1,-1,-1,-1 -> res=5'b10001 (-15). Digits 0,0,0,0 -> res=5'b00000, res_qm=5'b11111. Digits {1,1} x4 -> res=0.
3. WIDTH=4, res_ready=0 after completion, d_valid held 1 -> d_ready=0, res stable for 10 cycles. Raise res_ready -> the first digit of word 2 is accepted in the same cycle; word 2 (+1,+1,+1,+1 -> 5'b01111) completes 4 cycles later.
4. Continuous stream of 3 words, res_ready=1, d_valid=1 every cycle -> d_ready never 0, 3 results on cycles 5, 9, 13 after the first accept, all values correct.
5. WIDTH=4, accept 2 digits (+1,+1), pulse clr, then digits -1,0,0,0 -> res=5'b11000 (-8); partial word discarded; no spurious res_valid.
6. Assert rst_n low mid-word and while in HOLD -> res_valid=0, res=0, d_ready=1 immediately after release; next 4 digits yield a correct fresh word.
